// File: rtl/mem_ctrl_pkg.sv
// Shared types for the MEM stage controller.
//   mem_op_t    : decoded EX/MEM memory operation (encoding 11 is treated as none)
//   mem_state_t : controller FSM state, also exported on the fsm_state debug port
//   decode_op   : maps the raw 2-bit mem_op field onto mem_op_t
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_LOAD,
    MEM_STORE
  } mem_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } mem_state_t;

  function automatic mem_op_t decode_op(input logic [1:0] op);
    mem_op_t r;
    r = MEM_NONE;
    case (op)
      2'b01:   r = MEM_LOAD;
      2'b10:   r = MEM_STORE;
      default: r = MEM_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port bundle between the MEM stage controller (master) and the
// data memory (slave).
//   dmem_req   master->slave  request valid
//   dmem_we    master->slave  1 = store, 0 = load
//   dmem_addr  master->slave  word-aligned byte address
//   dmem_wdata master->slave  store data
//   dmem_ack   slave->master  request accepted/completed
//   dmem_rdata slave->master  load data, valid in the ack cycle
//
// Handshake: the master raises dmem_req with we/addr/wdata stable and holds all
// of them unchanged until it sees dmem_ack=1 at a clock edge (transfer done) or
// it gives up on a timeout. dmem_ack is only meaningful while dmem_req=1; an ack
// seen with dmem_req=0 is ignored. dmem_rdata is sampled in the ack cycle only.
interface mem_stage_ctrl_if #(
  parameter int WordSize = 32
);
  logic                dmem_req;
  logic                dmem_we;
  logic [WordSize-1:0] dmem_addr;
  logic [WordSize-1:0] dmem_wdata;
  logic                dmem_ack;
  logic [WordSize-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl_flush.sv
// Branch flush counter.
//   clk, rst      clock, asynchronous active-high reset
//   branch_taken  taken branch in EX/MEM; only honoured while stall=0
//   stall         pipeline frozen: counter neither loads nor decrements
//   flush         high while the counter is non-zero
// A new taken branch reloads the full count rather than adding to it.
module flush_counter #(
  parameter int FlushCycles = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic branch_taken,
  input  logic stall,
  output logic flush
);
  localparam int CW = $clog2(FlushCycles + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!stall) begin
      if (branch_taken) begin
        cnt <= CW'(FlushCycles);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign flush = (cnt != '0);
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller behind the EX/MEM pipeline register.
//   clk, rst       clock, asynchronous active-high reset
//   mem_op         00 none, 01 load, 10 store, 11 none
//   alu_out        byte address for memory ops, result for non-memory ops
//   mem_data       store data
//   rdn            destination register
//   branch_taken   taken branch, drives the flush counter
//   dmem           data-memory port (master side)
//   stall          freezes PC and upstream pipeline registers while in REQ
//   flush          clears IF/ID and ID/EX
//   wb_valid/rdn/data  one-cycle writeback towards WB
//   err            one-cycle pulse on misaligned access or request timeout
//   fsm_state      controller state, for observation only
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WordSize      = 32,
  parameter int TimeoutCycles = 16,
  parameter int FlushCycles   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mem_op,
  input  logic [WordSize-1:0] alu_out,
  input  logic [WordSize-1:0] mem_data,
  input  logic [4:0]          rdn,
  input  logic                branch_taken,
  mem_stage_ctrl_if.master    dmem,
  output logic                stall,
  output logic                flush,
  output logic                wb_valid,
  output logic [4:0]          wb_rdn,
  output logic [WordSize-1:0] wb_data,
  output logic                err,
  output mem_state_t          fsm_state
);
  localparam int TW = $clog2(TimeoutCycles + 1);

  mem_state_t          state, state_nxt;
  mem_op_t             op;
  logic                is_mem, misaligned, timeout;
  logic [TW-1:0]       timer;
  logic                we_q;
  logic [WordSize-1:0] addr_q, wdata_q;
  logic [4:0]          rdn_q;

  assign op         = decode_op(mem_op);
  assign is_mem     = (op != MEM_NONE);
  assign misaligned = (alu_out[1:0] != 2'b00);
  // timer holds the number of REQ cycles already completed, so the
  // TimeoutCycles-th REQ cycle is the last one.
  assign timeout    = (timer == TW'(TimeoutCycles - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; ack in the timeout cycle still completes the access.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (is_mem && !misaligned) state_nxt = S_REQ;
      S_REQ: begin
        if (dmem.dmem_ack)  state_nxt = S_RESP;
        else if (timeout)   state_nxt = S_IDLE;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    dmem.dmem_req = 1'b0;
    stall         = 1'b0;
    if (state == S_REQ) begin
      dmem.dmem_req = 1'b1;
      stall         = 1'b1;
    end
  end

  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign fsm_state       = state;

  // Request registers, timer, writeback register and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdn_q    <= '0;
      wb_valid <= 1'b0;
      wb_rdn   <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (!is_mem) begin
            wb_valid <= (rdn != 5'd0);
            wb_rdn   <= rdn;
            wb_data  <= alu_out;
          end else if (misaligned) begin
            err <= 1'b1;
          end else begin
            we_q    <= (op == MEM_STORE);
            addr_q  <= {alu_out[WordSize-1:2], 2'b00};
            wdata_q <= mem_data;
            rdn_q   <= rdn;
          end
        end
        S_REQ: begin
          if (dmem.dmem_ack) begin
            // Load data is captured at ack and presented during RESP.
            if (!we_q) begin
              wb_valid <= 1'b1;
              wb_rdn   <= rdn_q;
              wb_data  <= dmem.dmem_rdata;
            end
          end else if (timeout) begin
            err <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  flush_counter #(
    .FlushCycles(FlushCycles)
  ) u_flush (
    .clk         (clk),
    .rst         (rst),
    .branch_taken(branch_taken),
    .stall       (stall),
    .flush       (flush)
  );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
  import mem_ctrl_pkg::*;

  localparam int T  = 16;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_op;
  logic [31:0] alu_out, mem_data;
  logic [4:0]  rdn;
  logic        branch_taken;
  logic        stall, flush, wb_valid, err;
  logic [4:0]  wb_rdn;
  logic [31:0] wb_data;
  mem_state_t  fsm_state;

  mem_stage_ctrl_if #(.WordSize(32)) dif ();

  mem_stage_ctrl #(
    .WordSize(32), .TimeoutCycles(T), .FlushCycles(FC)
  ) dut (
    .clk(clk), .rst(rst), .mem_op(mem_op), .alu_out(alu_out),
    .mem_data(mem_data), .rdn(rdn), .branch_taken(branch_taken),
    .dmem(dif), .stall(stall), .flush(flush), .wb_valid(wb_valid),
    .wb_rdn(wb_rdn), .wb_data(wb_data), .err(err), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int flush_left = 0;            // reference: remaining flush cycles
  logic [31:0] exp_q[$];         // expected writeback data

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("%s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the flush reference follows the stated rule using the
  // stall value the model expects for the cycle that is ending.
  task automatic tick(input bit stalled);
    if (!stalled) begin
      if (branch_taken)        flush_left = FC;
      else if (flush_left > 0) flush_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_inputs();
    mem_op       = 2'b00;
    rdn          = 5'd0;
    branch_taken = 1'b0;
    alu_out      = $urandom;
    mem_data     = $urandom;
    dif.dmem_ack   = 1'($urandom_range(0, 1));
    dif.dmem_rdata = $urandom;
  endtask

  // One EX/MEM instruction. ack_lat = REQ cycle carrying ack (0 = never).
  task automatic run_op(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd,
                        input logic br, input int ack_lat, input logic [31:0] rdata);
    bit is_mem, aligned, acked;
    int n;
    is_mem  = (op == 2'b01) || (op == 2'b10);
    aligned = (addr[1:0] == 2'b00);
    acked   = (ack_lat >= 1) && (ack_lat <= T);
    n       = acked ? ack_lat : T;

    chk("pre_err", 32'(err), 0);
    chk("pre_wb_valid", 32'(wb_valid), 0);
    chk("idle_req", 32'(dif.dmem_req), 0);
    chk("idle_stall", 32'(stall), 0);
    chk("flush", 32'(flush), 32'(flush_left != 0));
    mem_op = op; alu_out = addr; mem_data = data; rdn = rd; branch_taken = br;
    dif.dmem_ack = 1'($urandom_range(0, 1));   // ack while idle must be ignored
    dif.dmem_rdata = $urandom;
    tick(0);
    set_idle_inputs();

    if (!is_mem) begin
      chk("alu_wb_valid", 32'(wb_valid), 32'(rd != 0));
      if (rd != 0) begin
        exp_q.push_back(addr);
        chk("alu_wb_rdn", 32'(wb_rdn), 32'(rd));
        chk("alu_wb_data", wb_data, exp_q.pop_front());
      end
      chk("alu_err", 32'(err), 0);
      chk("alu_req", 32'(dif.dmem_req), 0);
      chk("flush", 32'(flush), 32'(flush_left != 0));
      tick(0);
    end else if (!aligned) begin
      chk("mis_err", 32'(err), 1);
      chk("mis_wb_valid", 32'(wb_valid), 0);
      chk("mis_req", 32'(dif.dmem_req), 0);
      chk("mis_stall", 32'(stall), 0);
      chk("flush", 32'(flush), 32'(flush_left != 0));
      tick(0);
    end else begin
      for (int k = 1; k <= n; k++) begin
        chk("req", 32'(dif.dmem_req), 1);
        chk("stall", 32'(stall), 1);
        chk("we", 32'(dif.dmem_we), 32'(op == 2'b10));
        chk("addr", dif.dmem_addr, addr);
        chk("wdata", dif.dmem_wdata, data);
        chk("req_err", 32'(err), 0);
        chk("req_wb_valid", 32'(wb_valid), 0);
        chk("flush", 32'(flush), 32'(flush_left != 0));
        branch_taken   = 1'($urandom_range(0, 1));   // ignored while stalled
        dif.dmem_ack   = (k == ack_lat);
        dif.dmem_rdata = (k == ack_lat) ? rdata : $urandom;
        tick(1);
      end
      set_idle_inputs();
      chk("post_req", 32'(dif.dmem_req), 0);
      chk("post_stall", 32'(stall), 0);
      chk("flush", 32'(flush), 32'(flush_left != 0));
      if (acked) begin
        chk("resp_err", 32'(err), 0);
        chk("resp_wb_valid", 32'(wb_valid), 32'(op == 2'b01));
        if (op == 2'b01) begin
          exp_q.push_back(rdata);
          chk("resp_wb_rdn", 32'(wb_rdn), 32'(rd));
          chk("resp_wb_data", wb_data, exp_q.pop_front());
        end
      end else begin
        chk("tmo_err", 32'(err), 1);
        chk("tmo_wb_valid", 32'(wb_valid), 0);
      end
      tick(0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    int          lat;

    // reset
    rst = 1'b1;
    set_idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dif.dmem_req), 0);
    chk("rst_we", 32'(dif.dmem_we), 0);
    chk("rst_addr", dif.dmem_addr, 0);
    chk("rst_wdata", dif.dmem_wdata, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_rdn", 32'(wb_rdn), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_state", 32'(fsm_state), 32'(S_IDLE));
    rst = 1'b0;
    tick(0);

    // directed cases
    run_op(2'b00, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 0, 32'h0);
    run_op(2'b01, 32'h0000_0100, 32'h0, 5'd9, 1'b0, 3, 32'hDEAD_BEEF);
    run_op(2'b10, 32'h0000_0200, 32'h0000_CAFE, 5'd3, 1'b0, 1, 32'h0);
    run_op(2'b01, 32'h0000_0400, 32'h0, 5'd4, 1'b0, 0, 32'h0);
    run_op(2'b01, 32'h0000_0102, 32'h0, 5'd6, 1'b0, 1, 32'h0);
    run_op(2'b01, 32'h0000_0300, 32'h0, 5'd7, 1'b1, 4, 32'h1357_9BDF);
    run_op(2'b01, 32'h0000_0500, 32'h0, 5'd8, 1'b0, T, 32'hA5A5_5A5A);
    run_op(2'b00, 32'h0000_7777, 32'h0, 5'd0, 1'b1, 0, 32'h0);
    run_op(2'b11, 32'h0000_0042, 32'h0, 5'd1, 1'b1, 0, 32'h0);
    run_op(2'b10, 32'h0000_0601, 32'h1, 5'd2, 1'b0, 1, 32'h0);

    // reset in the middle of a request
    mem_op = 2'b01; alu_out = 32'h0000_0800; rdn = 5'd10; branch_taken = 1'b0;
    dif.dmem_ack = 1'b0;
    tick(0);
    set_idle_inputs();
    dif.dmem_ack = 1'b0;
    chk("mid_req_before", 32'(dif.dmem_req), 1);
    tick(1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(dif.dmem_req), 0);
    chk("mid_rst_stall", 32'(stall), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush_left = 0;
    tick(0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_wb_valid", 32'(wb_valid), 0);
    chk("mid_rst_state", 32'(fsm_state), 32'(S_IDLE));

    // randomized instructions
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      case ($urandom_range(0, 7))
        0:       lat = 0;
        1:       lat = T;
        default: lat = $urandom_range(1, 6);
      endcase
      run_op(op, a, $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), lat, $urandom);
    end

    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
